// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter (GBA cart front-end and USB FIFO bridge).
// Cart has default priority; an aging counter bounds USB wait; a watchdog aborts hung transfers.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 16,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cart_req,
  input  logic        cart_we,
  input  logic [25:0] cart_addr,
  input  logic [1:0]  cart_width,
  input  logic [15:0] cart_wr_data,
  output logic [15:0] cart_rd_data,
  output logic        cart_done,
  input  logic        usb_req,
  input  logic        usb_we,
  input  logic [25:0] usb_addr,
  input  logic [31:0] usb_wr_data,
  output logic [31:0] usb_rd_data,
  output logic        usb_done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [25:0] mem_addr,
  output logic [1:0]  mem_data_width,
  output logic [31:0] mem_wr_data,
  input  logic        mem_rd_ready,
  input  logic        mem_wr_ready,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  input  logic        err_clr,
  output logic        err_sticky
);

  // state   | meaning
  // IDLE    | arbitrate; latch the winning transfer
  // ISSUE   | wait for ready, then strobe mem_rd/mem_wr
  // WAIT_RD | wait for read data (ready drop -> retry)
  // WAIT_WR | confirm write accepted (ready drop -> retry)
  // RESP    | owner done pulse is visible this cycle

  localparam int unsigned      WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [7:0]       AGE_MAX = 8'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_RD = 3'd2,
    S_WAIT_WR = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t          state_q;
  logic            owner_usb_q;
  logic            we_q;
  logic [WD_W-1:0] wdog_q;
  logic [7:0]      usb_age_q, usb_age_d;
  logic            cart_armed_q, cart_armed_d;
  logic            mem_rd_q, mem_wr_q;
  logic [25:0]     mem_addr_q;
  logic [1:0]      mem_width_q;
  logic [31:0]     mem_wr_data_q;
  logic [15:0]     cart_rd_data_q;
  logic [31:0]     usb_rd_data_q;
  logic            cart_done_q, usb_done_q;
  logic            err_q;

  logic in_idle, cart_elig, usb_starved, grant_usb, grant_cart, usb_owns, wd_expired;

  always_comb begin
    in_idle     = (state_q == S_IDLE);
    cart_elig   = cart_req & cart_armed_q;
    usb_starved = usb_req & (usb_age_q == AGE_MAX);
    grant_usb   = in_idle & usb_req & (usb_starved | ~cart_elig);
    grant_cart  = in_idle & cart_elig & ~usb_starved;
    usb_owns    = ~in_idle & owner_usb_q;
    wd_expired  = (wdog_q == WD_LAST);

    usb_age_d = usb_age_q;
    if (!usb_req || grant_usb) begin
      usb_age_d = '0;
    end else if (!usb_owns && (usb_age_q != AGE_MAX)) begin
      usb_age_d = usb_age_q + 8'd1;
    end

    // A dropped request re-arms even if it coincides with the cart's own RESP.
    cart_armed_d = cart_armed_q;
    if (!cart_req) begin
      cart_armed_d = 1'b1;
    end else if ((state_q == S_RESP) && !owner_usb_q) begin
      cart_armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      owner_usb_q    <= 1'b0;
      we_q           <= 1'b0;
      wdog_q         <= '0;
      usb_age_q      <= '0;
      cart_armed_q   <= 1'b1;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_width_q    <= '0;
      mem_wr_data_q  <= '0;
      cart_rd_data_q <= '0;
      usb_rd_data_q  <= '0;
      cart_done_q    <= 1'b0;
      usb_done_q     <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      cart_done_q  <= 1'b0;
      usb_done_q   <= 1'b0;
      usb_age_q    <= usb_age_d;
      cart_armed_q <= cart_armed_d;
      if (err_clr) err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (grant_usb) begin
            owner_usb_q   <= 1'b1;
            we_q          <= usb_we;
            mem_addr_q    <= usb_addr;
            mem_width_q   <= 2'b11;
            mem_wr_data_q <= usb_wr_data;
            wdog_q        <= '0;
            state_q       <= S_ISSUE;
          end else if (grant_cart) begin
            owner_usb_q   <= 1'b0;
            we_q          <= cart_we;
            mem_addr_q    <= cart_addr;
            mem_width_q   <= cart_width;
            mem_wr_data_q <= {16'h0000, cart_wr_data};
            wdog_q        <= '0;
            state_q       <= S_ISSUE;
          end
        end

        S_ISSUE, S_WAIT_RD, S_WAIT_WR: begin
          if (wd_expired) begin
            // Abort: zeroed read data with done, error latched over any err_clr.
            err_q   <= 1'b1;
            state_q <= S_RESP;
            if (owner_usb_q) begin
              usb_rd_data_q <= '0;
              usb_done_q    <= 1'b1;
            end else begin
              cart_rd_data_q <= '0;
              cart_done_q    <= 1'b1;
            end
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
            if (state_q == S_ISSUE) begin
              if (we_q && mem_wr_ready) begin
                mem_wr_q <= 1'b1;
                state_q  <= S_WAIT_WR;
              end else if (!we_q && mem_rd_ready) begin
                mem_rd_q <= 1'b1;
                state_q  <= S_WAIT_RD;
              end
            end else if (state_q == S_WAIT_RD) begin
              if (!mem_rd_ready) begin
                state_q <= S_ISSUE;
              end else if (mem_rd_valid) begin
                state_q <= S_RESP;
                if (owner_usb_q) begin
                  usb_rd_data_q <= mem_rd_data;
                  usb_done_q    <= 1'b1;
                end else begin
                  cart_rd_data_q <= mem_rd_data[15:0];
                  cart_done_q    <= 1'b1;
                end
              end
            end else begin
              if (!mem_wr_ready) begin
                state_q <= S_ISSUE;
              end else begin
                state_q <= S_RESP;
                if (owner_usb_q) usb_done_q  <= 1'b1;
                else             cart_done_q <= 1'b1;
              end
            end
          end
        end

        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cart_rd_data   = cart_rd_data_q;
  assign cart_done      = cart_done_q;
  assign usb_rd_data    = usb_rd_data_q;
  assign usb_done       = usb_done_q;
  assign mem_rd         = mem_rd_q;
  assign mem_wr         = mem_wr_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data_width = mem_width_q;
  assign mem_wr_data    = mem_wr_data_q;
  assign err_sticky     = err_q;

endmodule
